inv_sub_bytes_seq: RTL
======================

# inv_sub_bytes_seq

Sequential AES InvSubBytes unit for the decryption datapath. It takes one 128-bit state over a valid/ready handshake and applies the inverse S-box to all 16 bytes, `LANES` bytes per cycle. It then presents the result over a second valid/ready handshake. It is the decrypt-side counterpart of the combinational forward SubBytes block and sits between InvShiftRows and AddRoundKey in the inverse round.

## Interface
- `LANES`, default 4: bytes substituted per cycle; legal values 1, 2, 4, 8, 16. Derived `STEPS = 16/LANES`.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `data_in` holds a state to substitute.
- `in_ready` output 1: unit can accept a state.
- `data_in` input 128: input state; byte i = `data_in[8i+7:8i]`.
- `out_valid` output 1: `data_out` holds a finished result.
- `out_ready` input 1: downstream accepts the result.
- `data_out` output 128: result; byte i = InvSBox(input byte i), same bit positions.

## Operation
- FSM states are IDLE, BUSY and DONE.
  - **IDLE:** `in_ready`=1 and `out_valid`=0. When `in_valid`=1, the unit registers `data_in` into the working register, clears the step counter `cnt` and moves to BUSY.
  - **BUSY:** `in_ready`=0 and `out_valid`=0. Each cycle replaces bytes `cnt*LANES` through `cnt*LANES+LANES-1` of the working register with their inverse S-box values, then increments `cnt`. When `cnt`=`STEPS-1`, this final substitution also moves the FSM to DONE.
  - **DONE:** `out_valid`=1 and `in_ready`=0. When `out_ready`=1, the handshake completes and the FSM returns to IDLE.
- `data_out` is driven directly by the working register.
  - It is defined only while `out_valid`=1.
  - It holds stable from the rise of `out_valid` until the output handshake.
- `cnt` width is `max(1, clog2(STEPS))`. It never wraps in normal flow; it is cleared on accept.
- Substitution is a pure 8-bit table lookup (FIPS-197 inverse S-box), with no arithmetic carries. Each byte is processed exactly once per block.
- The unit ignores `in_valid` outside IDLE and `out_ready` outside DONE. Input data is sampled only on the accept edge, so `data_in` may change afterwards.
- A handshake is a rising edge where the valid and ready of the same side are both 1.

## Timing
- **Reset:** the FSM goes to IDLE, `cnt`=0 and the working register is 0, giving `in_ready`=1, `out_valid`=0 and `data_out`=128'h0 from the first cycle after reset.
- **Reset mid-operation:** reset takes precedence over every other event in any state. An in-flight block is discarded with no output.
- **Latency:** with the accept at edge T, `out_valid` is 1 after edge T+`STEPS`. For example, LANES=4 gives 4 cycles and LANES=16 gives 1 cycle.
- **Throughput:** at most one block per `STEPS`+2 cycles (accept, `STEPS` BUSY cycles, output handshake, IDLE). There is no overlap between blocks.
- **Backpressure:** with `out_ready` held at 0, the unit holds DONE indefinitely; `data_out` does not change and `in_ready` stays 0.

## Structure
- Shared package `aes_pkg` holds:
  - `AES_STATE_W` = 128 and `AES_BYTES` = 16;
  - the 256-entry 8-bit `INV_SBOX` constant array;
  - the forward `SBOX` constant array, moved here so both directions share one source.
- One sub-module, `inv_sbox_byte`: a combinational 8-bit in/out lookup from `INV_SBOX`, instantiated `LANES` times.
- Lane byte selection is an indexed part-select on the working register using `cnt`.

## Test plan
- **All-zero input:** LANES=4, `data_in`=128'h0 → `data_out`=16 bytes of 8'h52 and `out_valid` high exactly 4 cycles after the accept edge.
- **Byte ordering:** bytes 0..3 set to 63, 7c, ed, 16 and all others 00 → output bytes 0..3 = 00, 01, 53, ff; all others 52.
- **Exhaustive sweep:** 16 back-to-back blocks covering bytes 00..ff, each at LANES=1, 4 and 16 → every byte satisfies SBOX(InvSBox(x))=x.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in DONE → `data_out` constant, `in_ready`=0, and a new `in_valid` is ignored. Release → return to IDLE, accept the next block, throughput `STEPS`+2.
- **Reset mid-operation:** assert `rst` for one cycle during BUSY at `cnt`=2 → the next cycle shows IDLE, `in_ready`=1, `out_valid`=0, `data_out`=0, and the aborted block never appears.
- **Simultaneous events:** `in_valid`=1 held continuously with `out_ready`=1 → no accept occurs in DONE, and exactly one result is produced per accept.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Package  : aes_pkg
// Brief    : Shared AES constants, forward/inverse S-box tables and FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTES   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } isb_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage
`default_nettype wire

// File: rtl/inv_sub_bytes_seq_if.sv
`default_nettype none
// ============================================================================
// Interface : inv_sub_bytes_seq_if
// Brief     : Input and output valid/ready channels of the InvSubBytes unit.
// Revision  : 1.0 - initial release
// ============================================================================
interface inv_sub_bytes_seq_if;
    import aes_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [AES_STATE_W-1:0] data_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [AES_STATE_W-1:0] data_out;

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out
    );

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out
    );
endinterface
`default_nettype wire

// File: rtl/inv_sbox_byte.sv
`default_nettype none
// ============================================================================
// Module   : inv_sbox_byte
// Brief    : Combinational single-byte inverse S-box lookup.
// Revision : 1.0 - initial release
// ============================================================================
module inv_sbox_byte
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    assign o_byte = INV_SBOX[i_byte];
endmodule
`default_nettype wire

// File: rtl/inv_sub_bytes_seq.sv
`default_nettype none
// ============================================================================
// Module   : inv_sub_bytes_seq
// Brief    : Sequential AES InvSubBytes, LANES bytes substituted per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
)(
    input  logic                clk,
    input  logic                rst,
    inv_sub_bytes_seq_if.slave  bus
);
    localparam int STEPS          = AES_BYTES / LANES;
    localparam int c_cnt_w        = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int c_lane_w       = 8 * LANES;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(STEPS - 1);

    isb_state_e                 r_state;
    isb_state_e                 w_state_nxt;
    logic [c_cnt_w-1:0]         r_cnt;
    logic [AES_STATE_W-1:0]     r_work;
    logic                       w_accept;
    logic                       w_step;
    logic                       w_in_ready;
    logic                       w_out_valid;
    logic [6:0]                 w_base;
    logic [c_lane_w-1:0]        w_lane_in;
    logic [c_lane_w-1:0]        w_lane_out;

    // Lane window start bit: cnt * LANES bytes, expressed as a shift since LANES is a power of two.
    assign w_base    = 7'(r_cnt) << $clog2(c_lane_w);
    assign w_lane_in = r_work[w_base +: c_lane_w];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        inv_sbox_byte u_inv_sbox (
            .i_byte (w_lane_in[8*g +: 8]),
            .o_byte (w_lane_out[8*g +: 8])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_step = 1'b1;
                if (r_cnt == c_last_cnt) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The counter parks on its last value rather than wrapping; the next accept clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_work <= '0;
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_work <= bus.data_in;
        end else if (w_step) begin
            r_work[w_base +: c_lane_w] <= w_lane_out;
            if (r_cnt != c_last_cnt) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.data_out  = r_work;

endmodule
`default_nettype wire
